// File: rtl/store_beat_aligner.sv
`default_nettype none
// ============================================================================
// Module   : store_beat_aligner
// Purpose  : Queues CPU store requests and emits bus-aligned, lane-placed write
//            beats; boundary-crossing stores are split or rejected.
// Revision : 1.0
// ============================================================================
module store_beat_aligner #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 4,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [DATA_W/8-1:0]        out_be,
    output logic                       misalign_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_BEAT0 = 2'd1, S_BEAT1 = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic                err_q, split_q, from_fifo_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_data_q, d1_q;
    logic [NB-1:0]       out_be_q, be1_q;

    logic [ADDR_W-1:0]   fifo_addr_q  [DEPTH];
    logic [2*DATA_W-1:0] fifo_data_q  [DEPTH];
    logic [2*NB-1:0]     fifo_be_q    [DEPTH];
    logic                fifo_split_q [DEPTH];

    logic [DATA_W-1:0]   mask;
    logic [2*DATA_W-1:0] wide;
    logic [2*NB-1:0]     be_wide;
    logic [ADDR_W-1:0]   in_aligned;
    logic                in_legal, in_split, in_acc, fifo_empty;
    logic                slot, load_b1, load_head, load_byp, push, pop;
    int                  nbytes, off, shamt;

    // Place the request into a two-word lane window: lanes 0..NB-1 form beat 0,
    // lanes NB..2NB-1 form beat 1. Lane 0 is the most significant byte.
    always_comb begin
        off = int'(in_addr[OW-1:0]);
        case (in_size)
            2'd0:    nbytes = 4;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 1;
            default: nbytes = 8;
        endcase
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) mask[8*i +: 8] = 8'hFF;
        end
        in_legal = (nbytes <= NB) && (ALLOW_MISALIGN || ((off % nbytes) == 0));
        in_split = (off + nbytes) > NB;
        shamt    = (nbytes <= NB) ? 8 * (2*NB - nbytes - off) : 0;
        wide     = {{DATA_W{1'b0}}, in_data & mask} << shamt;
        be_wide  = '0;
        for (int j = 0; j < 2*NB; j++) begin
            if (j >= off && j < off + nbytes) be_wide[j] = 1'b1;
        end
    end

    assign in_aligned = {in_addr[ADDR_W-1:OW], {OW{1'b0}}};
    assign in_ready   = reset_n && (count_q < CW'(DEPTH));
    assign in_acc     = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);

    // An empty FIFO lets a fresh request go straight to the output register.
    always_comb begin
        state_d   = state_q;
        slot      = 1'b0;
        load_b1   = 1'b0;
        load_head = 1'b0;
        load_byp  = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_BEAT0: begin
                if (out_ready && split_q) begin
                    state_d = S_BEAT1;
                    load_b1 = 1'b1;
                    pop     = from_fifo_q;
                end else begin
                    slot = out_ready;
                end
            end
            S_BEAT1: slot = out_ready;
            default: slot = 1'b1;
        endcase
        if (slot) begin
            if (!fifo_empty) begin
                state_d   = S_BEAT0;
                load_head = 1'b1;
                pop       = !fifo_split_q[rd_ptr_q];
            end else if (in_acc && in_legal) begin
                state_d  = S_BEAT0;
                load_byp = 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end
    end

    assign push = in_acc && in_legal && !load_byp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= in_aligned;
            fifo_data_q[wr_ptr_q]  <= wide;
            fifo_be_q[wr_ptr_q]    <= be_wide;
            fifo_split_q[wr_ptr_q] <= in_split;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            from_fifo_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_be_q    <= '0;
            d1_q        <= '0;
            be1_q       <= '0;
        end else begin
            err_q    <= in_acc && !in_legal;
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_q + CW'(push) - CW'(pop);
            if (load_b1) begin
                out_addr_q <= out_addr_q + ADDR_W'(NB);
                out_data_q <= d1_q;
                out_be_q   <= be1_q;
            end else if (load_head) begin
                out_addr_q  <= fifo_addr_q[rd_ptr_q];
                out_data_q  <= fifo_data_q[rd_ptr_q][2*DATA_W-1:DATA_W];
                out_be_q    <= fifo_be_q[rd_ptr_q][NB-1:0];
                d1_q        <= fifo_data_q[rd_ptr_q][DATA_W-1:0];
                be1_q       <= fifo_be_q[rd_ptr_q][2*NB-1:NB];
                split_q     <= fifo_split_q[rd_ptr_q];
                from_fifo_q <= 1'b1;
            end else if (load_byp) begin
                out_addr_q  <= in_aligned;
                out_data_q  <= wide[2*DATA_W-1:DATA_W];
                out_be_q    <= be_wide[NB-1:0];
                d1_q        <= wide[DATA_W-1:0];
                be1_q       <= be_wide[2*NB-1:NB];
                split_q     <= in_split;
                from_fifo_q <= 1'b0;
            end
        end
    end

    assign out_valid    = (state_q != S_EMPTY);
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign out_be       = out_be_q;
    assign misalign_err = err_q;
    assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_store_beat_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_beat_aligner
// Purpose  : Directed bench for store_beat_aligner (32-bit split/reject, 64-bit).
// Revision : 1.0
// ============================================================================
module tb_store_beat_aligner;
    logic        clk = 1'b0;
    logic        reset_n;
    int          checks = 0;
    int          errors = 0;

    logic        a_in_valid, a_out_ready;
    logic [31:0] a_in_addr, a_in_data;
    logic [1:0]  a_in_size;
    logic        a_in_ready, a_out_valid, a_err;
    logic [31:0] a_out_addr, a_out_data;
    logic [3:0]  a_out_be;
    logic [2:0]  a_count;

    logic        b_in_ready, b_out_valid, b_err;
    logic [31:0] b_out_addr, b_out_data;
    logic [3:0]  b_out_be;
    logic [2:0]  b_count;

    logic        c_in_valid, c_out_ready;
    logic [31:0] c_in_addr;
    logic [63:0] c_in_data;
    logic [1:0]  c_in_size;
    logic        c_in_ready, c_out_valid, c_err;
    logic [31:0] c_out_addr;
    logic [63:0] c_out_data;
    logic [7:0]  c_out_be;
    logic [2:0]  c_count;

    always #5 clk = ~clk;

    store_beat_aligner #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .ALLOW_MISALIGN(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .in_size(a_in_size),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
        .out_data(a_out_data), .out_be(a_out_be), .misalign_err(a_err), .count(a_count));

    store_beat_aligner #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .ALLOW_MISALIGN(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .in_size(a_in_size),
        .out_valid(b_out_valid), .out_ready(a_out_ready), .out_addr(b_out_addr),
        .out_data(b_out_data), .out_be(b_out_be), .misalign_err(b_err), .count(b_count));

    store_beat_aligner #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .ALLOW_MISALIGN(1'b1)) u_c (
        .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_addr(c_in_addr), .in_data(c_in_data), .in_size(c_in_size),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_addr(c_out_addr),
        .out_data(c_out_data), .out_be(c_out_be), .misalign_err(c_err), .count(c_count));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        a_in_valid = 1'b1;
        a_in_addr  = addr;
        a_in_data  = data;
        a_in_size  = size;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        a_in_valid = 1'b0; a_in_addr = '0; a_in_data = '0; a_in_size = '0; a_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_addr = '0; c_in_data = '0; c_in_size = '0; c_out_ready = 1'b1;
        #1;
        chk("rst_in_ready", a_in_ready, 0);
        step(); step();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_addr", a_out_addr, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_be", a_out_be, 0);
        chk("rst_err", a_err, 0);
        chk("rst_count", a_count, 0);
        chk("rst_c_valid", c_out_valid, 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1);

        // Aligned word, byte and half stores
        send(32'h100, 32'hDEADBEEF, 2'd0); step(); a_in_valid = 1'b0;
        chk("sw_valid", a_out_valid, 1);
        chk("sw_addr", a_out_addr, 32'h100);
        chk("sw_data", a_out_data, 32'hDEADBEEF);
        chk("sw_be", a_out_be, 4'b1111);
        chk("sw_count", a_count, 0);
        step();
        chk("sw_drained", a_out_valid, 0);

        send(32'h101, 32'h000000AB, 2'd2); step(); a_in_valid = 1'b0;
        chk("sb_data", a_out_data, 32'h00AB0000);
        chk("sb_be", a_out_be, 4'b0010);
        chk("sb_addr", a_out_addr, 32'h100);
        chk("sb_b_err", b_err, 0);
        step();

        send(32'h102, 32'h00001234, 2'd1); step(); a_in_valid = 1'b0;
        chk("sh_data", a_out_data, 32'h00001234);
        chk("sh_be", a_out_be, 4'b1100);
        chk("sh_b_data", b_out_data, 32'h00001234);
        step();

        // Crossing word: split on u_a, rejected on u_b
        send(32'h102, 32'h11223344, 2'd0); step(); a_in_valid = 1'b0;
        chk("split0_addr", a_out_addr, 32'h100);
        chk("split0_data", a_out_data, 32'h00001122);
        chk("split0_be", a_out_be, 4'b1100);
        chk("rej_b_valid", b_out_valid, 0);
        chk("rej_b_err", b_err, 1);
        chk("rej_b_count", b_count, 0);
        step();
        chk("split1_valid", a_out_valid, 1);
        chk("split1_addr", a_out_addr, 32'h104);
        chk("split1_data", a_out_data, 32'h33440000);
        chk("split1_be", a_out_be, 4'b0011);
        chk("rej_b_err_once", b_err, 0);
        step();
        chk("split_done", a_out_valid, 0);

        // Size 3 illegal at 32 bits
        send(32'h200, 32'h01020304, 2'd3); step(); a_in_valid = 1'b0;
        chk("sz3_err", a_err, 1);
        chk("sz3_valid", a_out_valid, 0);
        step();
        chk("sz3_err_clear", a_err, 0);

        // Back-to-back rejects on u_b; second split queues behind the first on u_a
        send(32'h102, 32'hA1A2A3A4, 2'd0); step();
        chk("b2b_err0", b_err, 1);
        send(32'h203, 32'hB1B2B3B4, 2'd0); step(); a_in_valid = 1'b0;
        chk("b2b_err1", b_err, 1);
        chk("b2b_a_count", a_count, 1);
        chk("b2b_a_beat1", a_out_addr, 32'h104);
        step();
        chk("b2b_err_clear", b_err, 0);
        chk("b2b_a_second0", a_out_data, 32'h000000B1);
        step();
        chk("b2b_a_second1", a_out_data, 32'hB2B3B400);
        chk("b2b_a_count0", a_count, 0);
        step(); step(); step();

        // Backpressure: fill output register plus FIFO, then drain
        a_out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            logic acc;
            send(32'h300 + 32'(4*k), 32'(k), 2'd0);
            acc = a_in_ready;
            step();
            if (acc) k++;
        end
        a_in_valid = 1'b0;
        chk("full_accepted", 32'(k), 5);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_count", a_count, 4);
        chk("full_head_addr", a_out_addr, 32'h300);
        step(); step();
        chk("hold_addr", a_out_addr, 32'h300);
        chk("hold_data", a_out_data, 32'h0);
        chk("hold_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", a_out_valid, 1);
            chk("drain_addr", a_out_addr, 32'h300 + 32'(4*i));
            chk("drain_data", a_out_data, 32'(i));
            step();
        end
        chk("drain_empty", a_out_valid, 0);
        chk("drain_count", a_count, 0);

        // Reset while beat 1 pending
        a_out_ready = 1'b0;
        send(32'h102, 32'hCAFEF00D, 2'd0); step(); a_in_valid = 1'b0;
        a_out_ready = 1'b1; step();
        a_out_ready = 1'b0;
        send(32'h500, 32'h77777777, 2'd0); step(); a_in_valid = 1'b0;
        chk("pre_rst_addr", a_out_addr, 32'h104);
        chk("pre_rst_count", a_count, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", a_out_valid, 0);
        chk("midrst_count", a_count, 0);
        step();
        reset_n = 1'b1;
        a_out_ready = 1'b1;
        send(32'h400, 32'h00000055, 2'd0); step(); a_in_valid = 1'b0;
        chk("postrst_valid", a_out_valid, 1);
        chk("postrst_addr", a_out_addr, 32'h400);
        chk("postrst_data", a_out_data, 32'h55);
        chk("postrst_be", a_out_be, 4'hF);
        step();
        chk("postrst_single", a_out_valid, 0);

        // 64-bit bus
        c_in_valid = 1'b1; c_in_addr = 32'h208; c_in_data = 64'h0102030405060708; c_in_size = 2'd3;
        step(); c_in_valid = 1'b0;
        chk("c_sd_addr", c_out_addr, 32'h208);
        chk("c_sd_data", c_out_data, 64'h0102030405060708);
        chk("c_sd_be", c_out_be, 8'hFF);
        chk("c_sd_err", c_err, 0);
        step();
        c_in_valid = 1'b1; c_in_addr = 32'h20C; c_in_data = 64'hAABBCCDD; c_in_size = 2'd0;
        step(); c_in_valid = 1'b0;
        chk("c_sw_data", c_out_data, 64'h00000000AABBCCDD);
        chk("c_sw_be", c_out_be, 8'hF0);
        step();
        c_in_valid = 1'b1; c_in_addr = 32'h20E; c_in_data = 64'h11223344; c_in_size = 2'd0;
        step(); c_in_valid = 1'b0;
        chk("c_split0_data", c_out_data, 64'h0000000000001122);
        chk("c_split0_be", c_out_be, 8'hC0);
        step();
        chk("c_split1_addr", c_out_addr, 32'h210);
        chk("c_split1_data", c_out_data, 64'h3344000000000000);
        chk("c_split1_be", c_out_be, 8'h03);
        step();
        chk("c_done", c_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/store_beat_aligner.md
# store_beat_aligner

Parametrised, buffered store-data aligner between the CPU memory stage and the data-memory write port. It accepts store requests (address, raw data, size) through a valid/ready handshake and queues them in a small FIFO. It emits bus-aligned write beats with lane-placed data and per-byte write enables. Stores that cross a bus-word boundary are either split into two beats or rejected with an error pulse.

## Interface
- DATA_W, 32, bus data width; 32 or 64.
- ADDR_W, 32, byte-address width.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- ALLOW_MISALIGN, 1, 1 = split boundary-crossing stores; 0 = reject any non-naturally-aligned store.
- NB = DATA_W/8, OW = log2(NB) (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock; the block's single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_addr  in  ADDR_W  byte address.
- in_data  in  DATA_W  store value, right-justified (byte store in [7:0]).
- in_size  in  2  0 = 4 bytes, 1 = 2 bytes, 2 = 1 byte, 3 = 8 bytes (legal only when DATA_W=64).
- out_valid  out  1  write beat valid.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_addr  out  ADDR_W  bus-word-aligned address (low OW bits 0).
- out_data  out  DATA_W  lane-placed data; unused lanes 0.
- out_be  out  NB  byte enables.
- misalign_err  out  1  one-cycle pulse per rejected request.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.

## Operation
- Lane convention: lane j = out_data[DATA_W-1-8j -: 8], enabled by out_be[j].
- Access byte k (k=0 is the most significant byte of the n-byte value) maps to lane offset+k, where offset = in_addr[OW-1:0].
- Validation happens at acceptance.
  - Illegal size: size 3 with DATA_W=32, or n > NB.
  - Misalignment with ALLOW_MISALIGN=0: offset % n ≠ 0.
  - A failing request is accepted normally but is not enqueued. misalign_err pulses in the following cycle.
- With ALLOW_MISALIGN=1, any offset is legal.
  - Non-crossing store (offset+n ≤ NB): one beat.
  - Crossing store: two beats.
    - Beat 0: addr = aligned A, lanes offset..NB-1.
    - Beat 1: addr = A+NB, lanes 0..offset+n-NB-1.
- Output FSM, states:
  - EMPTY: output register invalid.
  - BEAT0: single beat or first beat of a split, valid.
  - BEAT1: second beat of a split, valid.
- FSM transitions:
  - EMPTY → BEAT0 when FIFO non-empty.
  - BEAT0 + handshake: if split → BEAT1. Otherwise → BEAT0 if FIFO non-empty, else → EMPTY.
  - BEAT1 + handshake: → BEAT0 if FIFO non-empty, else → EMPTY.
- The FIFO head is popped when its last beat is loaded into the output register, so a split entry stays in the FIFO until its second beat is loaded.
- Beats are emitted in strict request order. No write combining.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_addr=0, out_data=0, out_be=0, misalign_err=0, count=0.
  - FIFO pointers 0, FSM in EMPTY.
  - in_ready=0 while reset_n is low, and 1 in the first cycle after.
- in_ready = (count < DEPTH). It does not depend on out_ready; no push at full even if a pop occurs in the same cycle.
- Latency: a request accepted in cycle N into an empty block gives out_valid=1 in cycle N+1. A split store's beat 1 appears in the cycle after the beat-0 handshake.
- Throughput: one beat per cycle with out_ready held high.
- out_addr, out_data and out_be stay stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged.
- Reset mid-operation discards all queued entries, any pending beat 1, and any pending error pulse.
- Two back-to-back rejected requests produce two consecutive misalign_err pulses.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, DATA_W=32 → one beat next cycle: addr 0x100, data 0xDEADBEEF, be 4'b1111.
- SB addr 0x101, data 0xAB → data 0x00AB0000, be 4'b0010. SH addr 0x102, data 0x1234 → data 0x00001234, be 4'b1100.
- SW addr 0x102, data 0x11223344, ALLOW_MISALIGN=1:
  - Beat 0: addr 0x100, data 0x00001122, be 4'b1100.
  - Beat 1: addr 0x104, data 0x33440000, be 4'b0011.
  - With ALLOW_MISALIGN=0: no beat, a single misalign_err pulse, count stays 0.
- DEPTH=4, out_ready=0, 6 requests offered:
  - 5 accepted (1 in the output register, 4 in the FIFO), then in_ready=0 and count=4.
  - Outputs hold stable.
  - After out_ready=1, beats drain in order, one per cycle.
- Size 3 with DATA_W=32 → rejected with misalign_err. Size 3 at addr 0x208, DATA_W=64 → one beat, be 8'hFF.
- reset_n low while BEAT1 is pending → out_valid=0 immediately, count=0. The next SW request after release → normal one-beat response.
